// File: rtl/q_pkg.sv
// Shared Q-learning definitions: state/action widths, action names, the
// policy-reader FSM states and the Q-table address packing {state, action}.
// Also imported by the update pipeline.
package q_pkg;
    localparam int STATE_W     = 6;
    localparam int ACTION_W    = 2;
    localparam int NUM_ACTIONS = 4;
    localparam int ADDR_W      = STATE_W + ACTION_W;

    typedef enum logic [ACTION_W-1:0] {
        ACT_LEFT  = 2'd0,
        ACT_UP    = 2'd1,
        ACT_RIGHT = 2'd2,
        ACT_DOWN  = 2'd3
    } action_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2,
        RD_RESP  = 2'd3
    } rd_state_e;

    function automatic logic [ADDR_W-1:0] q_addr(input logic [STATE_W-1:0]  s,
                                                  input logic [ACTION_W-1:0] a);
        return {s, a};
    endfunction
endpackage

// File: rtl/qtable_policy_reader_acc.sv
// qargmax_acc: running argmax over the four action values of one state.
//   en    : a new (d_q, d_a) sample is present this cycle
//   load  : sample is the first of the state; replaces whatever was held
//   nxt_* : best value/action including this cycle's sample (combinational),
//           so the caller can register the final result on the same edge
//           that absorbs the last sample.
// Unsigned compare, replaces only on strictly greater, so with samples
// arriving in action order a tie keeps the lower action index.
module qargmax_acc
    import q_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d_q,
    input  logic [ACTION_W-1:0]   d_a,
    output logic [DATA_WIDTH-1:0] nxt_q,
    output logic [ACTION_W-1:0]   nxt_a
);
    logic [DATA_WIDTH-1:0] best_q;
    logic [ACTION_W-1:0]   best_a;

    always_comb begin
        nxt_q = best_q;
        nxt_a = best_a;
        if (load || (d_q > best_q)) begin
            nxt_q = d_q;
            nxt_a = d_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q <= '0;
            best_a <= '0;
        end else if (en) begin
            best_q <= nxt_q;
            best_a <= nxt_a;
        end
    end
endmodule

// File: rtl/qtable_policy_reader.sv
// qtable_policy_reader: greedy-policy reader on the Q table's second read port.
// Evaluates one state (req_valid/req_ready) or sweeps states 0..63
// (sweep_start pulse), reading the four actions of the state and returning
// argmax action and its Q value on resp_* (valid/ready, held until taken).
//   req_*    : single-state query in
//   sweep_*  : sweep trigger, wins over a same-cycle request
//   rd_*     : synchronous read port, data one clock after rd_en
//   resp_*   : result out, resp_last marks state 63 of a sweep
// Timing: accept edge E, reads issue from E (4 cycles), last data lands at
// E+5 and the result is registered on that same edge.
module qtable_policy_reader
    import q_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int STATE_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [STATE_WIDTH-1:0] req_state,
    input  logic                   sweep_start,
    output logic                   busy,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [STATE_WIDTH-1:0] resp_state,
    output logic [1:0]             resp_action,
    output logic [DATA_WIDTH-1:0]  resp_q,
    output logic                   resp_last
);
    rd_state_e              state;
    logic [STATE_WIDTH-1:0] cur_state;
    logic                   sweep;
    logic                   rdy_q;      // registered "in IDLE and out of reset"
    logic                   cap_vld;    // rd_data carries a reply this cycle
    logic [ACTION_W-1:0]    cap_a;      // action index of that reply
    logic [DATA_WIDTH-1:0]  nxt_q;
    logic [ACTION_W-1:0]    nxt_a;

    // A same-cycle sweep_start steals the slot, so the request is refused.
    assign req_ready = rdy_q && !sweep_start;

    // Reply tracking: the action index travels alongside the one-cycle read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld <= 1'b0;
            cap_a   <= '0;
        end else begin
            cap_vld <= rd_en;
            cap_a   <= rd_addr[ACTION_W-1:0];
        end
    end

    qargmax_acc #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .en    (cap_vld),
        .load  (cap_a == '0),
        .d_q   (rd_data),
        .d_a   (cap_a),
        .nxt_q (nxt_q),
        .nxt_a (nxt_a)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RD_IDLE;
            cur_state   <= '0;
            sweep       <= 1'b0;
            rdy_q       <= 1'b0;
            busy        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            resp_valid  <= 1'b0;
            resp_state  <= '0;
            resp_action <= '0;
            resp_q      <= '0;
            resp_last   <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    rdy_q <= 1'b1;
                    if (sweep_start || (req_valid && rdy_q)) begin
                        sweep     <= sweep_start;
                        cur_state <= sweep_start ? '0 : req_state;
                        rd_addr   <= q_addr(sweep_start ? '0 : req_state, '0);
                        rd_en     <= 1'b1;
                        busy      <= 1'b1;
                        rdy_q     <= 1'b0;
                        state     <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (rd_addr[ACTION_W-1:0] == ACT_DOWN) begin
                        rd_en <= 1'b0;
                        state <= RD_DRAIN;
                    end else begin
                        rd_addr <= q_addr(cur_state, rd_addr[ACTION_W-1:0] + 2'd1);
                    end
                end
                RD_DRAIN: begin
                    // Last reply is in the accumulator's combinational path now.
                    resp_valid  <= 1'b1;
                    resp_state  <= cur_state;
                    resp_action <= nxt_a;
                    resp_q      <= nxt_q;
                    resp_last   <= sweep && (&cur_state);
                    state       <= RD_RESP;
                end
                RD_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (sweep && !resp_last) begin
                            cur_state <= cur_state + STATE_WIDTH'(1);
                            rd_addr   <= q_addr(cur_state + STATE_WIDTH'(1), '0);
                            rd_en     <= 1'b1;
                            state     <= RD_ISSUE;
                        end else begin
                            sweep <= 1'b0;
                            busy  <= 1'b0;
                            rdy_q <= 1'b1;
                            state <= RD_IDLE;
                        end
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qtable_policy_reader.sv
module tb_qtable_policy_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_state = '0;
    logic        sweep_start = 1'b0;
    logic        busy;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [5:0]  resp_state;
    logic [1:0]  resp_action;
    logic [31:0] resp_q;
    logic        resp_last;

    always #5 clk = ~clk;

    qtable_policy_reader dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .sweep_start(sweep_start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_state(resp_state),
        .resp_action(resp_action), .resp_q(resp_q), .resp_last(resp_last)
    );

    // Q table: synchronous read port
    logic [31:0] mem [0:255];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: greedy action = lowest action whose value equals the maximum.
    typedef struct { int s; int a; logic [31:0] q; bit last; } exp_t;
    exp_t exp_q[$];

    function automatic exp_t model(int s, bit last);
        exp_t e;
        logic [31:0] mx;
        mx = mem[s*4];
        for (int a = 1; a < 4; a++) if (mem[s*4+a] > mx) mx = mem[s*4+a];
        e.a = -1;
        for (int a = 3; a >= 0; a--) if (mem[s*4+a] == mx) e.a = a;
        e.s = s; e.q = mx; e.last = last;
        return e;
    endfunction

    // resp_ready driver: 0 = held low, 1 = held high, 2 = random
    int rdy_mode = 1;
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: resp_ready = 1'b0;
            1: resp_ready = 1'b1;
            default: resp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor + compare, all on the falling edge.
    int n_resp = 0, n_last = 0;
    int got_s, got_a; logic [31:0] got_q; bit got_last;
    bit prev_v = 0, prev_r = 0;
    logic [40:0] prev_f;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0;
        end else begin
            if (sweep_start && !busy)
                for (int s = 0; s < 64; s++) exp_q.push_back(model(s, s == 63));
            else if (req_valid && req_ready)
                exp_q.push_back(model(req_state, 0));
            if (prev_v && !prev_r)
                chk("hold", {resp_valid, resp_state, resp_action, resp_q, resp_last}, {1'b1, prev_f});
            if (resp_valid) chk("no_read_in_resp", 64'(rd_en), 64'(0));
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) chk("unexpected_resp", 64'(resp_state), 64'hDEAD);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp", {resp_state, resp_action, resp_q, resp_last},
                        {6'(e.s), 2'(e.a), e.q, e.last});
                end
                n_resp++;
                if (resp_last) n_last++;
                got_s = resp_state; got_a = resp_action; got_q = resp_q; got_last = resp_last;
            end
            prev_v = resp_valid; prev_r = resp_ready;
            prev_f = {resp_state, resp_action, resp_q, resp_last};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_query(input int s);
        int n = 0;
        req_valid = 1'b1; req_state = 6'(s);
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        if (!req_ready) chk("query_accept_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || resp_valid) && n < bound);
        if (busy || resp_valid) chk("idle_timeout", 64'(busy), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic pulse_sweep();
        sweep_start = 1'b1;
        tick(1);
        sweep_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, rdcnt;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // reset state
        tick(2);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_outs", {busy, rd_en, rd_addr, resp_valid, resp_state, resp_action, resp_q, resp_last}, 0);
        rst = 1'b0;
        tick(2);
        chk("idle_req_ready", 64'(req_ready), 1);

        // Q(5,*)={10,40,40,7}: tie between 1 and 2 -> 1; latency 5
        mem[20] = 10; mem[21] = 40; mem[22] = 40; mem[23] = 7;
        do_query(5);
        n = 0; rdcnt = 0;
        do begin @(negedge clk); n++; if (rd_en) rdcnt++; end while (!resp_valid && n < 20);
        chk("latency", 64'(n - 1), 5);
        chk("rd_en_cycles", 64'(rdcnt), 4);
        wait_idle(50);
        chk("q5_result", {32'(got_a), got_q, 32'(got_last)}, {32'd1, 32'd40, 32'd0});

        // all zero -> action 0; then unsigned max at action 3
        do_query(9); wait_idle(50);
        chk("q9_zero", {32'(got_a), got_q}, {32'd0, 32'd0});
        mem[39] = 32'hFFFF_FFFF;
        do_query(9); wait_idle(50);
        chk("q9_unsigned", {32'(got_a), got_q}, {32'd3, 32'hFFFF_FFFF});

        // stall: result held, no reads, no new accept
        rdy_mode = 0; tick(1);
        do_query(5);
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_state", {rd_en, req_ready, resp_valid, resp_action, resp_q},
                {1'b0, 1'b0, 1'b1, 2'd1, 32'd40});
        end
        rdy_mode = 1;
        wait_idle(50);
        chk("stall_release", {32'(got_s), 32'(got_a)}, {32'd5, 32'd1});

        // sweep, Q(s,a)=4s+a, ready high then random stalls
        for (int i = 0; i < 256; i++) mem[i] = i;
        for (int m = 1; m <= 2; m++) begin
            rdy_mode = m;
            n_resp = 0; n_last = 0;
            pulse_sweep();
            wait_idle(3000);
            chk("sweep_count", {32'(n_resp), 32'(n_last)}, {32'd64, 32'd1});
            chk("sweep_tail", {32'(got_s), 32'(got_a), got_q}, {32'd63, 32'd3, 32'd255});
            chk("sweep_drained", {32'(exp_q.size()), 32'(busy)}, 0);
        end

        // random table with frequent ties, random stalls
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
        rdy_mode = 2;
        n_resp = 0;
        pulse_sweep();
        wait_idle(3000);
        chk("rand_sweep_count", 64'(n_resp), 64);

        // same-cycle sweep_start and req_valid: sweep wins, request refused
        rdy_mode = 1;
        n_resp = 0;
        sweep_start = 1'b1; req_valid = 1'b1; req_state = 6'd7;
        @(negedge clk);
        chk("collision_req_ready", 64'(req_ready), 0);
        @(posedge clk); #1;
        sweep_start = 1'b0; req_valid = 1'b0;
        wait_idle(3000);
        chk("collision_sweep", {32'(n_resp), 32'(exp_q.size())}, {32'd64, 32'd0});

        // random single queries
        for (int k = 0; k < 25; k++) begin
            int s;
            s = $urandom_range(0, 63);
            for (int a = 0; a < 4; a++)
                mem[s*4+a] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2));
            rdy_mode = $urandom_range(1, 2);
            do_query(s);
            wait_idle(200);
        end

        // reset in the middle of a sweep, right as state 20 starts issuing
        rdy_mode = 1;
        pulse_sweep();
        n = 0;
        do begin @(negedge clk); n++; end while (!(resp_valid && resp_state == 6'd19) && n < 500);
        @(posedge clk); #1;
        chk("state20_issue", {rd_en, rd_addr}, {1'b1, 8'd80});
        rst = 1'b1;
        #1;
        chk("abort_outs", {rd_en, resp_valid, busy, req_ready}, 0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        n_resp = 0;
        tick(10);
        chk("after_abort", {32'(n_resp), busy, resp_valid, req_ready}, {32'd0, 3'b001});
        do_query(21);
        wait_idle(50);
        chk("after_abort_query", {32'(n_resp), 32'(got_s)}, {32'd1, 32'd21});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
